// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared types and constants for the boot program loader
package prog_loader_pkg;

    // Byte width of the host link and of every frame field
    localparam int BYTE_W = 8;

    // Default frame start marker
    localparam logic [BYTE_W-1:0] SYNC_BYTE_DEF = 8'hA5;

    // Loader sequencing states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_HI,
        ST_LO,
        ST_WRITE,
        ST_CHECK,
        ST_DONE
    } state_t;

endpackage

// File: rtl/prog_loader_byte_to_word.sv
// rtl/prog_loader_byte_to_word.sv - high-byte capture and running XOR checksum
module prog_loader_byte_to_word
    import prog_loader_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                hi_en,
    input  logic                lo_en,
    input  logic [BYTE_W-1:0]   data,
    output logic [2*BYTE_W-1:0] word,
    output logic [BYTE_W-1:0]   chk
);

    logic [BYTE_W-1:0] hi_q;
    logic [BYTE_W-1:0] chk_q;

    // Hold the high byte until its partner arrives; fold every data byte into the checksum
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q  <= '0;
            chk_q <= '0;
        end else if (clr) begin
            hi_q  <= '0;
            chk_q <= '0;
        end else if (hi_en) begin
            hi_q  <= data;
            chk_q <= chk_q ^ data;
        end else if (lo_en) begin
            chk_q <= chk_q ^ data;
        end
    end

    // The low byte is taken straight from the link so the word is ready on the LO handshake
    assign word = {hi_q, data};
    assign chk  = chk_q;

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte stream to instruction RAM loader with CPU hold
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 16,
    parameter logic [BYTE_W-1:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [BYTE_W-1:0]  in_data,
    output logic               in_ready,
    output logic               ram_we,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic [DATA_W-1:0]  ram_wdata,
    output logic               cpu_hold,
    output logic               busy,
    output logic               done,
    output logic               error
);

    state_t              state, state_d;
    logic [BYTE_W-1:0]   count_q, count_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d;
    logic                we_d, hold_d, busy_d, done_d, error_d;
    logic                fire, is_sync;
    logic                clr, hi_en, lo_en;
    logic [2*BYTE_W-1:0] word;
    logic [BYTE_W-1:0]   chk;

    // The only cycle the loader refuses a byte is the RAM write cycle
    assign in_ready = (state != ST_WRITE);
    assign fire     = in_valid && in_ready;
    assign is_sync  = (in_data == SYNC_BYTE);

    prog_loader_byte_to_word u_b2w (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .hi_en (hi_en),
        .lo_en (lo_en),
        .data  (in_data),
        .word  (word),
        .chk   (chk)
    );

    // Next-state and next-output decode; every output is registered below
    always_comb begin
        state_d = state;
        count_d = count_q;
        addr_d  = ram_addr;
        wdata_d = ram_wdata;
        we_d    = 1'b0;
        hold_d  = cpu_hold;
        busy_d  = busy;
        done_d  = done;
        error_d = error;
        clr     = 1'b0;
        hi_en   = 1'b0;
        lo_en   = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (fire && is_sync) begin
                    state_d = ST_COUNT;
                    busy_d  = 1'b1;
                    hold_d  = 1'b1;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    addr_d  = '0;
                    clr     = 1'b1;
                end
            end
            ST_COUNT: begin
                if (fire) begin
                    count_d = in_data;
                    state_d = (in_data == '0) ? ST_CHECK : ST_HI;
                end
            end
            ST_HI: begin
                if (fire) begin
                    hi_en   = 1'b1;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                if (fire) begin
                    lo_en   = 1'b1;
                    wdata_d = DATA_W'(word);
                    we_d    = 1'b1;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                addr_d  = ram_addr + ADDR_W'(1);
                count_d = count_q - BYTE_W'(1);
                state_d = (count_q == BYTE_W'(1)) ? ST_CHECK : ST_HI;
            end
            ST_CHECK: begin
                if (fire) begin
                    busy_d = 1'b0;
                    if (in_data == chk) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        error_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters and registered outputs; reset leaves the CPU held
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            count_q   <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_we    <= 1'b0;
            cpu_hold  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_d;
            count_q   <= count_d;
            ram_addr  <= addr_d;
            ram_wdata <= wdata_d;
            ram_we    <= we_d;
            cpu_hold  <= hold_d;
            busy      <= busy_d;
            done      <= done_d;
            error     <= error_d;
        end
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Boot-time program loader for the 16-bit CPU. It receives a framed byte stream on a valid/ready interface, assembles big-endian 16-bit instruction words and writes them into the CPU instruction RAM starting at address 0. It holds the CPU in reset through the whole load and releases it only after a frame passes its checksum. It sits between the external host link and the RAM write port and drives the CPU reset.

Parameters:
ADDR_W, 8, RAM word-address width (256 words)
DATA_W, 16, instruction word width (fixed two bytes per word)
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  host byte valid
in_data  input  8  host byte
in_ready  output  1  loader accepts byte this cycle; a byte transfers when in_valid && in_ready
ram_we  output  1  one-cycle RAM write strobe
ram_addr  output  ADDR_W  RAM word address
ram_wdata  output  DATA_W  RAM write data
cpu_hold  output  1  active-high reset to the CPU core
busy  output  1  frame in progress
done  output  1  last frame loaded with good checksum
error  output  1  last frame failed its checksum

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; ram_we=0; ram_addr=0; ram_wdata=0; cpu_hold=1; busy=0; done=0; error=0; word count, hi-byte register and checksum cleared. Reset mid-frame aborts the frame; partially written RAM contents stay as written.
- Frame format: SYNC_BYTE, N (word count 0..255), 2N data bytes (high byte first), CHK = XOR of all 2N data bytes (CHK=8'h00 when N=0).
- States: IDLE, COUNT, HI, LO, WRITE, CHECK, DONE.
- IDLE: in_ready=1; a byte != SYNC_BYTE is discarded; SYNC_BYTE -> COUNT, busy=1, cpu_hold=1, done=0, error=0, ram_addr=0, checksum=0.
- COUNT: accepted byte is loaded as N; N=0 -> CHECK, otherwise -> HI.
- HI: accepted byte stored as the high byte and XORed into the checksum -> LO.
- LO: accepted byte XORed into the checksum; ram_wdata={hi,byte} is registered -> WRITE.
- WRITE: in_ready=0; ram_we=1 for exactly this cycle at the current ram_addr. On exit ram_addr increments and the remaining count decrements; the next state is CHECK when the count reaches 0, otherwise HI.
- Write latency: ram_we is high in the cycle immediately after the LO-byte handshake.
- CHECK: the accepted byte is compared with the running checksum. On a match: -> DONE, done=1, busy=0, cpu_hold=0 from the next cycle. On a mismatch: -> IDLE, error=1, busy=0, cpu_hold stays 1.
- DONE: in_ready=1; non-sync bytes are ignored; SYNC_BYTE starts a reload, which reasserts cpu_hold and clears done the next cycle, then -> COUNT.
- in_ready=1 in every state except WRITE. Gaps in in_valid stall the FSM indefinitely with no timeout. Outputs are registered.
- ram_addr never wraps: at most 255 words are written, at addresses 0..254.
- A SYNC_BYTE value inside COUNT/HI/LO/CHECK is treated as data and does not resynchronise.

Decomposition:
- Shared package prog_loader_pkg: state enum, SYNC_BYTE default, frame-field constants.
- One natural sub-module: byte_to_word (hi-byte capture plus running XOR checksum), instantiated once.
- The FSM and address counter stay in prog_loader.

Test Plan:
- Good frame A5 02 40 02 44 02 04 -> writes RAM[0]=16'h4002, RAM[1]=16'h4402; each ram_we one cycle after its LO byte; done=1, cpu_hold=0, error=0.
- Same frame with CHK=05 -> both words still written; error=1, done=0, cpu_hold=1, state back to IDLE.
- Leading garbage 00 FF A5 01 20 01 21 with in_valid toggling every other cycle -> only RAM[0]=16'h2001 written; done=1.
- Empty frame A5 00 00 -> no ram_we; done=1, cpu_hold released.
- Reset pulse after A5 03 12 34 56 -> all outputs return to reset values, cpu_hold=1; a following frame A5 01 AB CD 66 writes RAM[0]=16'hABCD.
- After done, send A5 01 00 07 07 -> cpu_hold reasserts one cycle after A5; RAM[0]=16'h0007; done returns to 1.
